// File: rtl/dispatch_queue_pkg.sv
// Shared types, sizes and prefix helpers for the dispatch queue and its neighbours.
package dispatch_queue_pkg;

   localparam int unsigned N_WAY  = 2;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned LEAD_W = $clog2(N_WAY) + 1;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
   } dispatch_packet_t;

   // Number of consecutive ones starting at bit 0.
   function automatic logic [LEAD_W-1:0] lead_ones(input logic [N_WAY-1:0] bits);
      logic [LEAD_W-1:0] n;
      logic              run;
      n   = '0;
      run = 1'b1;
      for (int i = 0; i < N_WAY; i++) begin
         run = run & bits[i];
         if (run) n = n + LEAD_W'(1);
      end
      return n;
   endfunction

   // True when no set bit follows a clear bit (ones form a prefix from bit 0).
   function automatic logic is_prefix(input logic [N_WAY-1:0] bits);
      logic seen_zero;
      logic ok;
      seen_zero = 1'b0;
      ok        = 1'b1;
      for (int i = 0; i < N_WAY; i++) begin
         if (seen_zero && bits[i]) ok = 1'b0;
         if (!bits[i]) seen_zero = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Decode / back-end handshake bundle around the dispatch queue.
interface dispatch_queue_if;
   import dispatch_queue_pkg::*;

   dispatch_packet_t [N_WAY-1:0] dec_packet;
   logic [N_WAY-1:0]             dec_branch;
   logic [N_WAY-1:0]             dispatched;
   logic                         branch_haz;
   dispatch_packet_t [N_WAY-1:0] dispatch_packet;
   logic [N_WAY-1:0]             branch_inst;
   logic                         in_ready;
   logic [CNT_W-1:0]             free_slots;

   // Decode and back end together drive the queue inputs.
   modport master (
      output dec_packet, dec_branch, dispatched, branch_haz,
      input  dispatch_packet, branch_inst, in_ready, free_slots
   );

   // The queue itself.
   modport slave (
      input  dec_packet, dec_branch, dispatched, branch_haz,
      output dispatch_packet, branch_inst, in_ready, free_slots
   );
endinterface

// File: rtl/dispatch_queue.sv
// In-order circular buffer between decode and the R10K back end; flushes on mispredict.
module dispatch_queue
   import dispatch_queue_pkg::*;
(
   input logic            clock,
   input logic            reset,
   dispatch_queue_if.slave dq
);

   dispatch_packet_t  entry_q  [DEPTH];
   logic              branch_q [DEPTH];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [CNT_W-1:0]  count_q;

   logic [N_WAY-1:0]  slot_valid;
   logic [N_WAY-1:0]  dec_valid;
   logic [LEAD_W-1:0] deq_n;
   logic [LEAD_W-1:0] enq_raw;
   logic [LEAD_W-1:0] enq_n;
   logic              ready;

   // Present the oldest entries straight from registered state; derive enqueue/dequeue counts.
   always_comb begin
      ready             = (count_q <= CNT_W'(DEPTH - N_WAY));
      dq.in_ready       = ready;
      dq.free_slots     = CNT_W'(DEPTH) - count_q;
      slot_valid        = '0;
      dec_valid         = '0;
      dq.dispatch_packet = '0;
      dq.branch_inst    = '0;
      for (int i = 0; i < N_WAY; i++) begin
         slot_valid[i] = (CNT_W'(i) < count_q);
         dec_valid[i]  = dq.dec_packet[i].valid;
         if (slot_valid[i]) begin
            dq.dispatch_packet[i] = entry_q[head_q + PTR_W'(i)];
            dq.branch_inst[i]     = branch_q[head_q + PTR_W'(i)];
         end
      end
      deq_n   = lead_ones(dq.dispatched & slot_valid);
      enq_raw = lead_ones(dec_valid);
      enq_n   = ready ? enq_raw : '0;
   end

   // Queue state: flush and reset both empty it; otherwise retire at head and append at tail.
   always_ff @(posedge clock) begin
      if (reset || dq.branch_haz) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i]  <= '0;
            branch_q[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < N_WAY; i++) begin
            if (LEAD_W'(i) < enq_n) begin
               entry_q[tail_q + PTR_W'(i)]  <= dq.dec_packet[i];
               branch_q[tail_q + PTR_W'(i)] <= dq.dec_branch[i];
            end
         end
         head_q  <= head_q + PTR_W'(deq_n);
         tail_q  <= tail_q + PTR_W'(enq_n);
         count_q <= count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
      end
   end

   // Flag protocol violations: gapped dispatch acknowledgement, or decode pushing while not ready.
   always_ff @(posedge clock) begin
      if (!reset && !dq.branch_haz) begin
         assert (is_prefix(dq.dispatched))
            else $warning("dispatch_queue: non-prefix dispatched %b ignored", dq.dispatched);
         assert (!((enq_raw != '0) && !ready))
            else $warning("dispatch_queue: enqueue of %0d dropped while not ready", enq_raw);
      end
   end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed plus short random bench for dispatch_queue with a queue-based scoreboard.
module tb_dispatch_queue;
   import dispatch_queue_pkg::*;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        br;
   } model_t;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   int   seq;
   model_t model[$];

   dispatch_queue_if dq_if ();

   dispatch_queue dut (
      .clock (clock),
      .reset (reset),
      .dq    (dq_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   // Compare every output against the scoreboard contents.
   task automatic check_outputs(input string tag);
      for (int i = 0; i < N_WAY; i++) begin
         if (i < model.size()) begin
            chk({tag, "_valid"}, 64'(dq_if.dispatch_packet[i].valid), 64'd1);
            chk({tag, "_pc"},    64'(dq_if.dispatch_packet[i].pc),    64'(model[i].pc));
            chk({tag, "_inst"},  64'(dq_if.dispatch_packet[i].inst),  64'(model[i].inst));
            chk({tag, "_br"},    64'(dq_if.branch_inst[i]),           64'(model[i].br));
         end else begin
            chk({tag, "_valid0"}, 64'(dq_if.dispatch_packet[i].valid), 64'd0);
            chk({tag, "_br0"},    64'(dq_if.branch_inst[i]),           64'd0);
         end
      end
      chk({tag, "_free"},  64'(dq_if.free_slots), 64'(DEPTH - model.size()));
      chk({tag, "_ready"}, 64'(dq_if.in_ready),   64'(model.size() <= DEPTH - N_WAY));
   endtask

   task automatic clear_inputs();
      dq_if.dec_packet = '0;
      dq_if.dec_branch = '0;
      dq_if.dispatched = '0;
      dq_if.branch_haz = 1'b0;
   endtask

   // One clock: check current outputs, drive a group, update the scoreboard.
   task automatic cycle(input int n_enq, input logic [1:0] disp, input logic haz);
      model_t new_e[$];
      int     deq;
      bit     rdy;
      @(negedge clock);
      check_outputs("cyc");
      rdy = (model.size() <= DEPTH - N_WAY);
      for (int i = 0; i < N_WAY; i++) begin
         dispatch_packet_t p;
         model_t           m;
         logic             br;
         p  = '0;
         br = 1'b0;
         if (i < n_enq) begin
            p.valid = 1'b1;
            p.pc    = 32'h1000 + 32'(seq) * 32'd4;
            p.inst  = 32'hA5A5_0000 ^ 32'(seq);
            br      = ((seq % 3) == 1);
            m.pc    = p.pc;
            m.inst  = p.inst;
            m.br    = br;
            new_e.push_back(m);
            seq++;
         end
         dq_if.dec_packet[i] = p;
         dq_if.dec_branch[i] = br;
      end
      dq_if.dispatched = disp;
      dq_if.branch_haz = haz;
      if (haz) begin
         model.delete();
      end else begin
         deq = 0;
         if (disp[0] && model.size() >= 1) begin
            deq = 1;
            if (disp[1] && model.size() >= 2) deq = 2;
         end
         for (int i = 0; i < deq; i++) void'(model.pop_front());
         if (rdy) foreach (new_e[k]) model.push_back(new_e[k]);
      end
      @(posedge clock);
      #1;
      clear_inputs();
   endtask

   task automatic do_reset(input logic with_haz);
      @(negedge clock);
      clear_inputs();
      reset = 1'b1;
      dq_if.branch_haz = with_haz;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      clear_inputs();
      model.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      seq    = 0;
      reset  = 1'b1;
      clear_inputs();
      do_reset(1'b0);

      // Reset state
      chk("rst_free",   64'(dq_if.free_slots), 64'd16);
      chk("rst_ready",  64'(dq_if.in_ready), 64'd1);
      chk("rst_v0",     64'(dq_if.dispatch_packet[0].valid), 64'd0);
      chk("rst_v1",     64'(dq_if.dispatch_packet[1].valid), 64'd0);
      chk("rst_br",     64'(dq_if.branch_inst), 64'd0);

      // 1: three groups of two, nothing dispatched
      repeat (3) cycle(2, 2'b00, 1'b0);
      chk("t1_free", 64'(dq_if.free_slots), 64'd10);
      chk("t1_pc0",  64'(dq_if.dispatch_packet[0].pc), 64'h1000);
      chk("t1_pc1",  64'(dq_if.dispatch_packet[1].pc), 64'h1004);

      // 2: retire one then two
      cycle(0, 2'b01, 1'b0);
      chk("t2_pc0a", 64'(dq_if.dispatch_packet[0].pc), 64'h1004);
      cycle(0, 2'b11, 1'b0);
      chk("t2_free", 64'(dq_if.free_slots), 64'd13);
      chk("t2_pc0",  64'(dq_if.dispatch_packet[0].pc), 64'h100C);

      // 3: fill to 15, push into a full queue, then drain two
      repeat (6) cycle(2, 2'b00, 1'b0);
      chk("t3_free15",  64'(dq_if.free_slots), 64'd1);
      chk("t3_notready", 64'(dq_if.in_ready), 64'd0);
      cycle(2, 2'b00, 1'b0);
      chk("t3_drop",    64'(dq_if.free_slots), 64'd1);
      cycle(0, 2'b11, 1'b0);
      chk("t3_ready",   64'(dq_if.in_ready), 64'd1);
      chk("t3_free13",  64'(dq_if.free_slots), 64'd3);

      // 4: walk head to 14 with four entries, then retire across the wrap
      repeat (4) cycle(0, 2'b11, 1'b0);
      cycle(0, 2'b01, 1'b0);
      chk("t4_free", 64'(dq_if.free_slots), 64'd12);
      cycle(0, 2'b11, 1'b0);
      chk("t4_free2", 64'(dq_if.free_slots), 64'd14);
      check_outputs("t4_wrap");

      // 5: flush with simultaneous enqueue and dispatch
      repeat (3) cycle(2, 2'b00, 1'b0);
      cycle(1, 2'b00, 1'b0);
      chk("t5_free9", 64'(dq_if.free_slots), 64'd7);
      cycle(2, 2'b11, 1'b1);
      chk("t5_free",  64'(dq_if.free_slots), 64'd16);
      chk("t5_v0",    64'(dq_if.dispatch_packet[0].valid), 64'd0);
      chk("t5_v1",    64'(dq_if.dispatch_packet[1].valid), 64'd0);
      chk("t5_br",    64'(dq_if.branch_inst), 64'd0);

      // 6: gapped acknowledgement, then over-acknowledgement of a single entry
      cycle(2, 2'b00, 1'b0);
      cycle(0, 2'b10, 1'b0);
      chk("t6_gap",  64'(dq_if.free_slots), 64'd14);
      cycle(0, 2'b01, 1'b0);
      cycle(0, 2'b11, 1'b0);
      chk("t6_one",  64'(dq_if.free_slots), 64'd16);

      // Reset coinciding with a flush
      repeat (2) cycle(2, 2'b00, 1'b0);
      do_reset(1'b1);
      chk("rh_free", 64'(dq_if.free_slots), 64'd16);
      chk("rh_v0",   64'(dq_if.dispatch_packet[0].valid), 64'd0);

      // Short legal random traffic
      for (int n = 0; n < 80; n++) begin
         int          ne;
         logic [1:0]  d;
         int unsigned r;
         ne = (model.size() <= DEPTH - N_WAY) ? int'($urandom_range(0, 2)) : 0;
         r  = $urandom_range(0, 2);
         d  = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
         cycle(ne, d, ($urandom_range(0, 29) == 0));
      end

      // Drain
      for (int n = 0; n < 12 && model.size() > 0; n++) cycle(0, 2'b11, 1'b0);
      @(negedge clock);
      check_outputs("final");
      chk("final_free", 64'(dq_if.free_slots), 64'd16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
